// File: rtl/mux_gate_sequencer.sv
// Bit-serial logic unit: one shared 2x1 mux cell produces Y one bit per cycle, LSB first.
// Optional MUXSEQ_PARITY_EN adds a parity output of the completed result.
module mux_gate_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done
`ifdef MUXSEQ_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;

    logic             sel;
    logic             b_bit;
    logic             in0;
    logic             in1;
    logic             mux_out;
    logic [WIDTH-1:0] y_next;

    assign sel   = a_q[cnt];
    assign b_bit = b_q[cnt];

    // Each op is just a choice of what feeds the two mux data legs.
    always_comb begin
        in0 = 1'b0;
        in1 = 1'b0;
        unique case (op_q)
            3'b000: begin in0 = 1'b1;   in1 = 1'b0;   end
            3'b001: begin in0 = 1'b0;   in1 = b_bit;  end
            3'b010: begin in0 = b_bit;  in1 = 1'b1;   end
            3'b011: begin in0 = 1'b1;   in1 = ~b_bit; end
            3'b100: begin in0 = ~b_bit; in1 = 1'b0;   end
            3'b101: begin in0 = b_bit;  in1 = ~b_bit; end
            3'b110: begin in0 = ~b_bit; in1 = b_bit;  end
            3'b111: begin in0 = 1'b0;   in1 = 1'b1;   end
        endcase
    end

    assign mux_out = sel ? in1 : in0;

    always_comb begin
        y_next      = Y;
        y_next[cnt] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt    <= '0;
            Y      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef MUXSEQ_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        cnt   <= '0;
                        Y     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    Y <= y_next;
                    // Counter parks on the last index instead of wrapping.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
`ifdef MUXSEQ_PARITY_EN
                        parity <= ^y_next;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Scoreboard bench for mux_gate_sequencer (WIDTH=8).
// Expected results are queued at each accepted start and popped on done.
module tb_mux_gate_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Y;
    logic       busy;
    logic       done;
`ifdef MUXSEQ_PARITY_EN
    logic       parity;
`endif

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int done_cyc;
    int prev_done_cyc;

    logic [8:0] exp_q[$];

    mux_gate_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .busy  (busy),
        .done  (done)
`ifdef MUXSEQ_PARITY_EN
        ,
        .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model(input logic [2:0] o,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (o)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done) begin
            prev_done_cyc = done_cyc;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("y", Y, e[7:0]);
`ifdef MUXSEQ_PARITY_EN
                check("parity", parity, e[8]);
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic go(input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b);
        logic [7:0] r;
        r = model(o, a, b);
        exp_q.push_back({^r, r});
        op = o;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done is seen (left on the done negedge).
    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) return;
            if (busy) nbusy++;
            @(negedge clk);
        end
        check("timeout_done", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int nb;

    initial begin
        rst = 1'b1;
        start = 1'b1;
        op = 3'd7;
        A = 8'hFF;
        B = 8'hFF;
        done_cyc = 0;
        prev_done_cyc = 0;
        idle(3);
        check("rst_y", Y, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef MUXSEQ_PARITY_EN
        check("rst_parity", parity, 1'b0);
`endif
        start = 1'b0;
        rst = 1'b0;
        idle(2);
        check("idle_busy", busy, 1'b0);

        // NOT: busy exactly 8 cycles then one-cycle done
        go(3'd0, 8'h0F, 8'h00);
        wait_done(nb);
        check("not_busy_cycles", nb, 8);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("y_hold", Y, 8'hF0);

        go(3'd1, 8'hCC, 8'hAA);
        wait_done(nb);
        idle(2);
        go(3'd5, 8'hCC, 8'hAA);
        wait_done(nb);
        idle(2);

        // start during RUN is ignored
        go(3'd2, 8'h01, 8'h02);
        idle(2);
        start = 1'b1;
        A = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", busy, 1'b1);
        wait_done(nb);
        idle(12);
        check("no_extra_op", busy, 1'b0);

        // reset mid-run: abort, no done pulse
        go(3'd0, 8'h00, 8'h00);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_y", Y, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        exp_q.delete();
        idle(12);
        go(3'd7, 8'h5A, 8'h00);
        wait_done(nb);
        check("after_rst_busy", nb, 8);
        idle(1);

        // back-to-back: start held during DONE
        go(3'd3, 8'h3C, 8'h55);
        wait_done(nb);
        go(3'd4, 8'h3C, 8'h55);
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_low", done, 1'b0);
        wait_done(nb);
        @(negedge clk);
        check("done_spacing", done_cyc - prev_done_cyc, 9);

        go(3'd6, 8'hFF, 8'h0F);
        wait_done(nb);
        idle(1);
        go(3'd3, 8'h01, 8'h01);
        wait_done(nb);
        idle(1);

        for (int i = 0; i < 8; i++) begin
            go(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            wait_done(nb);
            idle(1);
        end

        idle(3);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_gate_sequencer.md
MUX_GATE_SEQUENCER -- requirements
Module: mux_gate_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, meaning: operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the block uses only this clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin one operation; sampled on clk rising edge.
REQ-005 op  input  3  function select: 000 NOT A, 001 AND, 010 OR, 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 BUF A.
REQ-006 A  input  WIDTH  operand A; also drives the mux select.
REQ-007 B  input  WIDTH  operand B; ignored for op 000 and 111.
REQ-008 Y  output  WIDTH  registered result.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking Y as valid.

Function
REQ-011 The block SHALL evaluate every result bit through a single shared 2x1 mux cell: Y[i] = A[i] ? in1 : in0.
REQ-012 in0/in1 per op SHALL be: NOT 1/0; AND 0/B; OR B/1; NAND 1/~B; NOR ~B/0; XOR B/~B; XNOR ~B/B; BUF 0/1.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-014 IDLE/DONE with start=1: on that edge, capture A, B and op into internal registers, clear bit counter to 0, clear Y to 0 and go to RUN.
REQ-015 IDLE with start=0: remain in IDLE; Y holds its value.
REQ-016 RUN: each edge writes bit cnt of Y, LSB first, from the captured operands, then increments cnt.
REQ-017 RUN: on the edge that writes bit WIDTH-1, go to DONE.
REQ-018 Latency: if start is sampled at edge k, Y is complete and done=1 after edge k+WIDTH (WIDTH=8: 8 cycles).
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE (one cycle).
REQ-020 DONE with start=0: go to IDLE; Y holds until the next accepted start.
REQ-021 start while busy=1 SHALL be ignored; captured operands are unaffected by input changes during RUN.
REQ-022 cnt SHALL be ceil(log2(WIDTH)) bits and SHALL never wrap past WIDTH-1 within one operation.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, Y=0, busy=0, done=0, cnt=0 and captured registers=0, with priority over start.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-025 After rst is released, the first start SHALL be accepted normally.

Configuration
REQ-026 Macro MUXSEQ_PARITY_EN.
- Defined: adds output port parity (1 bit) = XOR of all bits of the final Y; it updates on the edge entering DONE, resets to 0, and holds otherwise.
- Undefined: the parity port and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-027 rst then op=000, A=8'h0F, start for one cycle -> busy for 8 cycles, then done=1 for one cycle with Y=8'hF0.
REQ-028 op=001, A=8'hCC, B=8'hAA -> Y=8'h88; then op=101 with the same operands -> Y=8'h66.
REQ-029 Start op=010, A=8'h01, B=8'h02; at cycle 3 drive start=1, A=8'hFF -> ignored; Y=8'h03.
REQ-030 rst=1 while cnt=3 -> next cycle Y=0, busy=0, done=0 and no done pulse; a following op=111, A=8'h5A gives Y=8'h5A.
REQ-031 start held high during the DONE cycle -> new operation accepted that edge; busy=1 the next cycle; done pulses are 9 cycles apart.
REQ-032 MUXSEQ_PARITY_EN defined, op=110, A=8'hFF, B=8'h0F -> Y=8'h0F and parity=0; op=011, A=8'h01, B=8'h01 -> Y=8'hFE and parity=1.
